imm_gen_stage: RTL and testbench

- Registered successor to the combinational immediate generator. Accepts a fetched instruction plus its PC over a valid/ready handshake.
- Produces a sign-extended XLEN-wide immediate, a format code, a PC-relative target and an illegal-opcode flag, one cycle later.
- Contains a 2-entry skid buffer, so the fetch→decode boundary can take full-throughput backpressure without a combinational ready path.
- Adds XLEN generalisation, a CSR zero-extended immediate format and pipeline flush.

---
 rtl/imm_gen_pkg.sv | 31 +++
 rtl/imm_gen_stage_if.sv | 35 +++
 rtl/imm_decode.sv | 77 +++++++
 rtl/imm_gen_stage.sv | 106 ++++++++++
 tb/tb_imm_gen_stage.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared immediate format codes and RV opcode constants.
// Revision    : 1.0
// ============================================================================
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage_if
// Description : Fetch-side and decode-side handshake bundle of the stage.
// Revision    : 1.0
// ============================================================================
interface imm_gen_stage_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    imm_fmt_t        out_fmt;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    // Environment side: drives the instruction and the downstream ready.
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_pc, out_target, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational opcode decode into immediate, format, illegal.
// Revision    : 1.0
// ============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_CSR = 1'b1
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o,
    output logic            illegal_o
);
    logic       w_csr_en;
    logic [6:0] w_opcode;

    assign w_opcode = inst_i[6:0];

    generate
        if (EN_CSR) begin : g_csr_on
            assign w_csr_en = 1'b1;
        end else begin : g_csr_off
            assign w_csr_en = 1'b0;
        end
    endgenerate

    // Size casts of signed operands give the sign extension to XLEN.
    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (w_opcode)
            OP_IMM, LOAD, JALR: begin
                fmt_o = FMT_I;
                imm_o = XLEN'($signed(inst_i[31:20]));
            end
            STORE: begin
                fmt_o = FMT_S;
                imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
            end
            BRANCH: begin
                fmt_o = FMT_B;
                imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                       inst_i[11:8], 1'b0}));
            end
            LUI, AUIPC: begin
                fmt_o = FMT_U;
                imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
            end
            JAL: begin
                fmt_o = FMT_J;
                imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                       inst_i[30:21], 1'b0}));
            end
            SYSTEM: begin
                if (w_csr_en && inst_i[14]) begin
                    fmt_o = FMT_Z;
                    imm_o = XLEN'(inst_i[19:15]);
                end else if (w_csr_en) begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'($signed(inst_i[31:20]));
                end
            end
            OP: begin
                fmt_o = FMT_NONE;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Registered immediate generator with a 2-entry skid buffer.
// Revision    : 1.0
// ============================================================================
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_CSR = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    imm_gen_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_t        fmt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            illegal;
    } result_t;

    logic [XLEN-1:0] w_imm;
    imm_fmt_t        w_fmt;
    logic            w_illegal;
    result_t         w_new;

    result_t r_main_q, w_main_d;
    result_t r_skid_q, w_skid_d;
    logic    r_main_vld_q, w_main_vld_d;
    logic    r_skid_vld_q, w_skid_vld_d;
    logic    w_accept;
    logic    w_drain;

    imm_decode #(
        .XLEN   (XLEN),
        .EN_CSR (EN_CSR)
    ) u_decode (
        .inst_i    (bus.in_inst),
        .imm_o     (w_imm),
        .fmt_o     (w_fmt),
        .illegal_o (w_illegal)
    );

    assign w_new.imm     = w_imm;
    assign w_new.fmt     = w_fmt;
    assign w_new.pc      = bus.in_pc;
    assign w_new.target  = bus.in_pc + w_imm;
    assign w_new.illegal = w_illegal;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_drain  = r_main_vld_q & bus.out_ready;

    // Skid can only be full while main is full, so accept never coincides
    // with a skid-to-main move.
    always_comb begin
        w_main_d     = r_main_q;
        w_skid_d     = r_skid_q;
        w_main_vld_d = r_main_vld_q;
        w_skid_vld_d = r_skid_vld_q;
        if (flush) begin
            w_main_vld_d = 1'b0;
            w_skid_vld_d = 1'b0;
        end else if (!r_main_vld_q || w_drain) begin
            if (r_skid_vld_q) begin
                w_main_d     = r_skid_q;
                w_main_vld_d = 1'b1;
                w_skid_vld_d = 1'b0;
            end else if (w_accept) begin
                w_main_d     = w_new;
                w_main_vld_d = 1'b1;
            end else begin
                w_main_vld_d = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_d     = w_new;
            w_skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_q     <= '0;
            r_skid_q     <= '0;
            r_main_vld_q <= 1'b0;
            r_skid_vld_q <= 1'b0;
        end else begin
            r_main_q     <= w_main_d;
            r_skid_q     <= w_skid_d;
            r_main_vld_q <= w_main_vld_d;
            r_skid_vld_q <= w_skid_vld_d;
        end
    end

    assign bus.in_ready    = ~r_skid_vld_q;
    assign bus.out_valid   = r_main_vld_q;
    assign bus.out_imm     = r_main_q.imm;
    assign bus.out_fmt     = r_main_q.fmt;
    assign bus.out_pc      = r_main_q.pc;
    assign bus.out_target  = r_main_q.target;
    assign bus.out_illegal = r_main_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Vector table, handshake sequences and random stream vs model.
// Revision    : 1.0
// ============================================================================
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n_drained = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) bus32 ();
    imm_gen_stage_if #(.XLEN(64)) bus64 ();

    imm_gen_stage #(.XLEN(32), .EN_CSR(1'b1)) dut32 (
        .clk (clk), .rst (rst), .flush (flush), .bus (bus32)
    );
    imm_gen_stage #(.XLEN(64), .EN_CSR(1'b1)) dut64 (
        .clk (clk), .rst (rst), .flush (flush), .bus (bus64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decode written from the field rules as signed integer arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.pc  = pc;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67: begin
                e.fmt = 3'd1;
                v = longint'(inst[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            7'h73: begin
                if (inst[14]) begin
                    e.fmt = 3'd6;
                    v = longint'(inst[19:15]);
                end else begin
                    e.fmt = 3'd1;
                    v = longint'(inst[31:20]);
                    if (v >= 2048) v = v - 4096;
                end
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = longint'(inst[31:12]) * 4096;
                if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            7'h33: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] inst, input logic [63:0] pc);
        bus32.in_valid = v;
        bus64.in_valid = v;
        bus32.in_inst  = inst;
        bus64.in_inst  = inst;
        bus32.in_pc    = pc[31:0];
        bus64.in_pc    = pc;
    endtask

    task automatic set_ready(input logic r);
        bus32.out_ready = r;
        bus64.out_ready = r;
    endtask

    // Scoreboard monitor on the 32-bit instance, sampled mid-cycle.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_imm, prev_pc;
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] t32;
        if (rst || flush) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            chk("occ_out_valid", 64'(bus32.out_valid), 64'(sb.size() > 0));
            chk("occ_in_ready", 64'(bus32.in_ready), 64'(sb.size() < 2));
            if (hold_prev) begin
                chk("hold_imm", 64'(bus32.out_imm), 64'(prev_imm));
                chk("hold_pc", 64'(bus32.out_pc), 64'(prev_pc));
            end
            if (bus32.out_valid && bus32.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(bus32.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    t32 = e.pc[31:0] + e.imm[31:0];
                    chk("sb_imm", 64'(bus32.out_imm), 64'(e.imm[31:0]));
                    chk("sb_fmt", 64'(bus32.out_fmt), 64'(e.fmt));
                    chk("sb_pc", 64'(bus32.out_pc), 64'(e.pc[31:0]));
                    chk("sb_target", 64'(bus32.out_target), 64'(t32));
                    chk("sb_illegal", 64'(bus32.out_illegal), 64'(e.ill));
                    n_drained++;
                end
            end
            if (bus32.in_valid && bus32.in_ready)
                sb.push_back(ref_dec(bus32.in_inst, 64'(bus32.in_pc)));
            hold_prev = bus32.out_valid & ~bus32.out_ready;
            prev_imm  = bus32.out_imm;
            prev_pc   = bus32.out_pc;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid32"}, 64'(bus32.out_valid), 64'd0);
        chk({tag, "_ready32"}, 64'(bus32.in_ready), 64'd1);
        chk({tag, "_imm32"}, 64'(bus32.out_imm), 64'd0);
        chk({tag, "_pc32"}, 64'(bus32.out_pc), 64'd0);
        chk({tag, "_tgt32"}, 64'(bus32.out_target), 64'd0);
        chk({tag, "_fmt32"}, 64'(bus32.out_fmt), 64'd0);
        chk({tag, "_ill32"}, 64'(bus32.out_illegal), 64'd0);
        chk({tag, "_valid64"}, 64'(bus64.out_valid), 64'd0);
        chk({tag, "_ready64"}, 64'(bus64.in_ready), 64'd1);
        chk({tag, "_imm64"}, bus64.out_imm, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[13];
        logic [6:0]  opcs[11];
        logic [31:0] r;
        logic [63:0] t64;
        int          d0;
        logic        acc;

        vt[0]  = '{32'hFFF00093, 64'h0,    64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vt[1]  = '{32'hFE000EE3, 64'h100,  64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        vt[2]  = '{32'h123452B7, 64'h40,   64'h0000000012345000, 3'd4, 1'b0};
        vt[3]  = '{32'h8000006F, 64'h1000, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0};
        vt[4]  = '{32'h3401D073, 64'h8,    64'h3,                3'd6, 1'b0};
        vt[5]  = '{32'h0000007F, 64'h10,   64'h0,                3'd0, 1'b1};
        vt[6]  = '{32'hFE112C23, 64'h20,   64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
        vt[7]  = '{32'h00001017, 64'h200,  64'h1000,             3'd4, 1'b0};
        vt[8]  = '{32'h00B50533, 64'h30,   64'h0,                3'd0, 1'b0};
        vt[9]  = '{32'h00000073, 64'h34,   64'h0,                3'd1, 1'b0};
        vt[10] = '{32'h800000B7, 64'h44,   64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vt[11] = '{32'h7E001FE3, 64'h0,    64'hFFE,              3'd3, 1'b0};
        vt[12] = '{32'h7FF08067, 64'h50,   64'h7FF,              3'd1, 1'b0};

        set_in(1'b0, 32'h0, 64'h0);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // Table: one instruction at a time, checked one cycle after transfer.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1 set_in(1'b1, vt[i].inst, vt[i].pc);
            @(posedge clk); #1 set_in(1'b0, 32'h0, 64'h0);
            @(negedge clk);
            t64 = vt[i].pc + vt[i].imm;
            chk($sformatf("v%0d_valid32", i), 64'(bus32.out_valid), 64'd1);
            chk($sformatf("v%0d_imm32", i), 64'(bus32.out_imm), 64'(vt[i].imm[31:0]));
            chk($sformatf("v%0d_fmt32", i), 64'(bus32.out_fmt), 64'(vt[i].fmt));
            chk($sformatf("v%0d_ill32", i), 64'(bus32.out_illegal), 64'(vt[i].ill));
            chk($sformatf("v%0d_tgt32", i), 64'(bus32.out_target), 64'(t64[31:0]));
            chk($sformatf("v%0d_imm64", i), bus64.out_imm, vt[i].imm);
            chk($sformatf("v%0d_fmt64", i), 64'(bus64.out_fmt), 64'(vt[i].fmt));
            chk($sformatf("v%0d_ill64", i), 64'(bus64.out_illegal), 64'(vt[i].ill));
            chk($sformatf("v%0d_tgt64", i), bus64.out_target, t64);
            chk($sformatf("v%0d_pc64", i), bus64.out_pc, vt[i].pc);
        end
        @(posedge clk); #1;

        // Backpressure: A into main, B into skid, C stalled, then ordered drain.
        d0 = n_drained;
        set_ready(1'b0);
        set_in(1'b1, 32'h00100093, 64'hA00);
        @(posedge clk); #1 set_in(1'b1, 32'h00200093, 64'hB00);
        @(posedge clk); #1 set_in(1'b1, 32'h00300093, 64'hC00);
        @(negedge clk);
        chk("bp_in_ready", 64'(bus32.in_ready), 64'd0);
        chk("bp_hold_pc", 64'(bus32.out_pc), 64'hA00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_stall_ready", 64'(bus32.in_ready), 64'd0);
        chk("bp_stall_pc", 64'(bus32.out_pc), 64'hA00);
        @(posedge clk); #1 set_ready(1'b1);
        repeat (6) begin
            @(negedge clk);
            acc = bus32.in_valid & bus32.in_ready;
            @(posedge clk); #1;
            if (acc) set_in(1'b0, 32'h0, 64'h0);
        end
        chk("bp_drained", 64'(n_drained - d0), 64'd3);
        chk("bp_empty", 64'(bus32.out_valid), 64'd0);

        // Flush with main and skid full and an input offered.
        set_ready(1'b0);
        set_in(1'b1, 32'h00400093, 64'hD00);
        @(posedge clk); #1 set_in(1'b1, 32'h00500093, 64'hE00);
        @(posedge clk); #1 set_in(1'b1, 32'h00600093, 64'hF00);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        set_in(1'b0, 32'h0, 64'h0);
        set_ready(1'b1);
        @(negedge clk);
        chk("fl_valid32", 64'(bus32.out_valid), 64'd0);
        chk("fl_ready32", 64'(bus32.in_ready), 64'd1);
        chk("fl_valid64", 64'(bus64.out_valid), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("fl_quiet", 64'(bus32.out_valid), 64'd0);
        end

        // Flush while empty: offered item must be dropped.
        @(posedge clk); #1 set_in(1'b1, 32'h00700093, 64'h700);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        set_in(1'b0, 32'h0, 64'h0);
        @(negedge clk);
        chk("fl_drop_valid", 64'(bus32.out_valid), 64'd0);

        // Reset while holding a result.
        @(posedge clk); #1 set_ready(1'b0);
        set_in(1'b1, 32'hFFF00093, 64'h900);
        @(posedge clk); #1 set_in(1'b0, 32'h0, 64'h0);
        @(negedge clk);
        chk("rst_pre_valid", 64'(bus32.out_valid), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        set_ready(1'b1);
        @(negedge clk);
        chk_reset_vals("midrst");

        // Random stream against the scoreboard.
        opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h00};
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            r = $urandom();
            if (bus32.in_ready || !bus32.in_valid) begin
                logic [6:0] op;
                op = opcs[$urandom_range(0, 10)];
                if (op == 7'h00) op = 7'(r[6:0] | 7'h04);
                set_in(($urandom_range(0, 3) != 0), {r[31:7], op}, 64'($urandom()));
            end
            set_ready($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1 flush = 1'b0;
        set_in(1'b0, 32'h0, 64'h0);
        set_ready(1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_empty", 64'(bus32.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
